psum_acc_bank: RTL and testbench
================================

// Module: psum_acc_bank
// PURPOSE
//  Multi-pass partial-sum accumulator with post-processing for the corelet output path.
//  Sits between OFIFO read side and the psum SRAM write path.
//  Accumulates NUM_PASS vectors (one per kernel position) into DEPTH on-chip entries.
//  Then drains ReLU'd, saturated results with a valid/ready handshake.
//  Replaces the single-shot sfp stage: adds depth, pass counting, backpressure and a runtime mode.
// PARAMETERS
//  COL      8   lanes per vector (one per PE column)
//  PSUM_BW  16  signed lane width, in and out
//  ACC_BW   24  signed accumulator lane width (> PSUM_BW)
//  DEPTH    16  accumulator entries; AW = $clog2(DEPTH)
//  PASS_BW  4   width of pass count
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            synchronous, active-high
//  start      in   1            begin job (sampled only in IDLE)
//  num_pass   in   PASS_BW      passes per job; 0 treated as 1
//  num_addr   in   AW+1         entries per pass; 0 -> 1, >DEPTH -> DEPTH
//  relu_en    in   1            1: negative results forced to 0 on drain
//  in_valid   in   1            input vector valid
//  in_ready   out  1            accepting input (ACC state only)
//  in_data    in   COL*PSUM_BW  input vector, lane k at [k*PSUM_BW +: PSUM_BW]
//  out_valid  out  1            output vector valid (DRAIN state only)
//  out_ready  in   1            downstream accepts
//  out_data   out  COL*PSUM_BW  processed entry, same lane packing
//  busy       out  1            state != IDLE
//  done       out  1            one-cycle pulse after last drain transfer
//  ovf        out  1            (ACC_SAT_EN only) sticky saturation flag
// BEHAVIOUR
//  Reset: state IDLE; pass_cnt, addr_cnt, drain_ptr = 0; in_ready, out_valid, busy, done = 0.
//   out_data = 0 in IDLE. Accumulator contents not cleared (pass 0 overwrites).
//  FSM: IDLE -> ACC -> DRAIN -> IDLE.
//  IDLE: start=1 latches clamped num_pass/num_addr and relu_en; next cycle ACC.
//   Counters cleared on that transition.
//  ACC: in_ready=1. Each in_valid&&in_ready cycle:
//   pass_cnt==0 -> entry[addr_cnt] = sext(in_data); else entry[addr_cnt] += sext(in_data).
//   addr_cnt++; at addr_cnt==num_addr-1 it wraps to 0 and pass_cnt++.
//   Transfer at last addr of last pass -> DRAIN next cycle.
//   in_valid=0 cycles: no change.
//  DRAIN: out_valid=1; out_data = post(entry[drain_ptr]), driven combinationally from registers.
//   out_valid&&out_ready -> drain_ptr++. out_ready=0 -> data held stable.
//   Last entry transferred -> IDLE next cycle with done=1 for exactly that cycle.
//  Arithmetic: lanes signed two's complement, sign-extended to ACC_BW.
//   Accumulation wraps at ACC_BW (see ACC_SAT_EN).
//  post(): if relu_en && x<0 -> 0; then saturate to PSUM_BW signed range [-32768, 32767].
//  Ignored inputs:
//   - start outside IDLE ignored.
//   - in_valid outside ACC ignored (in_ready=0).
//   - out_ready outside DRAIN ignored.
//  Reset mid-job: returns to IDLE at once; partial results discarded, no done pulse.
//  Lanes are independent; all lanes of a vector share one handshake.
// CONFIGURATION
//  ACC_SAT_EN defined:
//   - accumulator add saturates at the ACC_BW signed limits instead of wrapping.
//   - port ovf exists: set when any lane saturates (add or output clamp), cleared only by reset or start.
//  ACC_SAT_EN undefined: wrapping accumulation; no ovf port; output clamp still applies.
// TESTING
//  1. Reset held 2 cycles -> busy=0, in_ready=0, out_valid=0, done=0, out_data=0.
//  2. num_pass=3, num_addr=2, relu_en=1; all lanes entry0: 5,7,-2; entry1: -3,-3,-3.
//     -> drains entry0=10, entry1=0 on all lanes; done pulses once; back to IDLE.
//  3. Same job, in_valid toggled 1/0 and out_ready low 5 cycles mid-drain.
//     -> identical results; out_data/out_valid stable while stalled; no beat lost or duplicated.
//  4. num_pass=4, relu_en=0; lanes 32767 x4 -> out 32767; lanes -32768 x4 -> out -32768.
//     (ACC_SAT_EN: ovf=1)
//  5. Reset asserted mid-ACC, then start num_pass=1, num_addr=1 with lanes=9 -> out 9 (no stale sum).
//  6. start pulsed during DRAIN -> ignored; num_pass=0 and num_addr=20 -> behave as 1 pass, 16 entries.

Source files
------------

// File: rtl/psum_acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : psum_acc_bank
// Brief    : Multi-pass partial-sum accumulator bank with ReLU/saturating
//            drain for the corelet output path. Optional macro: ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module psum_acc_bank #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 24,
    parameter int DEPTH   = 16,
    parameter int PASS_BW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_BW-1:0]       num_pass,
    input  logic [$clog2(DEPTH):0]   num_addr,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*PSUM_BW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*PSUM_BW-1:0]   out_data,
    output logic                     busy,
    output logic                     done
`ifdef ACC_SAT_EN
    ,
    output logic                     ovf
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0]        c_DEPTH_N = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0]      c_ONE_AW  = c_AW'(1);
    localparam logic [PASS_BW-1:0]   c_ONE_P   = PASS_BW'(1);
    localparam logic [PSUM_BW-1:0]   c_PMAX    = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0]   c_PMIN    = {1'b1, {(PSUM_BW-1){1'b0}}};
    localparam logic signed [ACC_BW-1:0] c_PMAX_EXT = {{(ACC_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] c_PMIN_EXT = {{(ACC_BW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
`ifdef ACC_SAT_EN
    localparam logic signed [ACC_BW-1:0] c_AMAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] c_AMIN = {1'b1, {(ACC_BW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state, w_state_next;
    logic [PASS_BW-1:0]     r_pass_cnt, r_last_pass, w_last_pass_in;
    logic [c_AW-1:0]        r_addr_cnt, r_drain_ptr, r_last_addr, w_last_addr_in;
    logic                   r_relu, r_done;
    logic [COL*ACC_BW-1:0]  r_acc [DEPTH];
    logic [COL*ACC_BW-1:0]  w_acc_next;
    logic [COL*PSUM_BW-1:0] w_post;
    logic                   w_in_fire, w_out_fire, w_addr_wrap, w_pass_last, w_drain_last;
`ifdef ACC_SAT_EN
    logic [COL-1:0]         w_add_sat, w_clamp;
    logic                   r_ovf;
`endif

    // Job sizes are stored as "last index" so the counters compare directly.
    always_comb begin
        w_last_pass_in = (num_pass == '0) ? '0 : num_pass - c_ONE_P;
        if (num_addr == '0)
            w_last_addr_in = '0;
        else if (num_addr > c_DEPTH_N)
            w_last_addr_in = c_AW'(DEPTH - 1);
        else
            w_last_addr_in = num_addr[c_AW-1:0] - c_ONE_AW;
    end

    assign w_in_fire    = (r_state == S_ACC) && in_valid;
    assign w_out_fire   = (r_state == S_DRAIN) && out_ready;
    assign w_addr_wrap  = (r_addr_cnt == r_last_addr);
    assign w_pass_last  = (r_pass_cnt == r_last_pass);
    assign w_drain_last = (r_drain_ptr == r_last_addr);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        out_data     = '0;
        done         = r_done;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_next = S_ACC;
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (w_in_fire && w_addr_wrap && w_pass_last)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = w_post;
                if (w_out_fire && w_drain_last)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pass_cnt  <= '0;
            r_addr_cnt  <= '0;
            r_drain_ptr <= '0;
            r_last_pass <= '0;
            r_last_addr <= '0;
            r_relu      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pass_cnt  <= '0;
                        r_addr_cnt  <= '0;
                        r_drain_ptr <= '0;
                        r_last_pass <= w_last_pass_in;
                        r_last_addr <= w_last_addr_in;
                        r_relu      <= relu_en;
                    end
                end
                S_ACC: begin
                    if (w_in_fire) begin
                        if (w_addr_wrap) begin
                            r_addr_cnt <= '0;
                            r_pass_cnt <= r_pass_cnt + c_ONE_P;
                        end else begin
                            r_addr_cnt <= r_addr_cnt + c_ONE_AW;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_drain_ptr <= r_drain_ptr + c_ONE_AW;
                        if (w_drain_last)
                            r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared: the first pass overwrites instead of adding.
    always_ff @(posedge clk) begin
        if (!reset && w_in_fire)
            r_acc[r_addr_cnt] <= w_acc_next;
    end

    for (genvar k = 0; k < COL; k++) begin : g_lane
        logic signed [ACC_BW-1:0] w_ext, w_old, w_sum, w_acc_val, w_rd, w_rl;
        logic                     w_hi, w_lo;

        assign w_ext = {{(ACC_BW-PSUM_BW){in_data[k*PSUM_BW+PSUM_BW-1]}}, in_data[k*PSUM_BW +: PSUM_BW]};
        assign w_old = r_acc[r_addr_cnt][k*ACC_BW +: ACC_BW];
        assign w_sum = w_old + w_ext;
`ifdef ACC_SAT_EN
        logic w_vf;
        // Overflow only when both operands share a sign the result lacks.
        assign w_vf         = (w_old[ACC_BW-1] == w_ext[ACC_BW-1]) && (w_sum[ACC_BW-1] != w_old[ACC_BW-1]);
        assign w_acc_val    = w_vf ? (w_old[ACC_BW-1] ? c_AMIN : c_AMAX) : w_sum;
        assign w_add_sat[k] = w_vf && (r_pass_cnt != '0);
        assign w_clamp[k]   = w_hi || w_lo;
`else
        assign w_acc_val = w_sum;
`endif
        assign w_acc_next[k*ACC_BW +: ACC_BW] = (r_pass_cnt == '0) ? w_ext : w_acc_val;

        assign w_rd = r_acc[r_drain_ptr][k*ACC_BW +: ACC_BW];
        assign w_rl = (r_relu && w_rd[ACC_BW-1]) ? '0 : w_rd;
        assign w_hi = (w_rl > c_PMAX_EXT);
        assign w_lo = (w_rl < c_PMIN_EXT);
        assign w_post[k*PSUM_BW +: PSUM_BW] = w_hi ? c_PMAX : (w_lo ? c_PMIN : w_rl[PSUM_BW-1:0]);
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_ovf <= 1'b0;
        else if ((w_in_fire && (|w_add_sat)) || (w_out_fire && (|w_clamp)))
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_acc_bank
// Brief    : Directed scoreboard bench for psum_acc_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_acc_bank;

    logic         clk = 1'b0;
    logic         reset, start, relu_en, in_valid, out_ready;
    logic [3:0]   num_pass;
    logic [4:0]   num_addr;
    logic [127:0] in_data;
    logic         in_ready, out_valid, busy, done;
    logic [127:0] out_data;
`ifdef ACC_SAT_EN
    logic         ovf;
`endif

    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_xfer   = 0;
    int           n_done   = 0;
    logic [127:0] sb [$];
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data  = '0;
    int           v [$];

    always #5 clk = ~clk;

    psum_acc_bank dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pass  (num_pass),
        .num_addr  (num_addr),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
`ifdef ACC_SAT_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each transfer, stall stability, done count.
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                if (sb.size() == 0)
                    chk("extra_beat", sb.size(), 1);
                else
                    chk("out_data", out_data, sb.pop_front());
            end
            if (done)
                n_done++;
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
    end

    task automatic run_job(input int np, input int na, input logic relu, input int vals[$],
                           input int step, input logic toggle, input int stall_at, input logic poke);
        int npe, nae, cyc, base, done_before;
        logic signed [23:0] m [16][8];
        logic [127:0] expv, vec;
        logic took, stalled;
        npe = (np == 0) ? 1 : np;
        nae = (na == 0) ? 1 : ((na > 16) ? 16 : na);

        for (int p = 0; p < npe; p++)
            for (int a = 0; a < nae; a++)
                for (int k = 0; k < 8; k++) begin
                    logic signed [15:0] x;
                    int xi;
                    x  = 16'(vals[p*nae+a] + k*step);
                    xi = x;
                    m[a][k] = (p == 0) ? 24'(xi) : m[a][k] + 24'(xi);
                end
        for (int a = 0; a < nae; a++) begin
            for (int k = 0; k < 8; k++) begin
                int r;
                r = m[a][k];
                if (relu && r < 0) r = 0;
                if (r > 32767) r = 32767;
                if (r < -32768) r = -32768;
                expv[k*16 +: 16] = 16'(r);
            end
            sb.push_back(expv);
        end

        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
        num_pass = 4'(np);
        num_addr = 5'(na);
        relu_en  = relu;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("acc_entry", {busy, in_ready, out_valid}, 3'b110);

        for (int i = 0; i < npe*nae; i++) begin
            for (int k = 0; k < 8; k++) vec[k*16 +: 16] = 16'(vals[i] + k*step);
            in_data  = vec;
            in_valid = 1'b1;
            cyc = 0;
            do begin
                took = in_ready;
                @(posedge clk); #1; cyc++;
            end while (!took && cyc < 50);
            if (!took) chk("in_timeout", took, 1'b1);
            if (toggle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        chk("drain_entry", {busy, in_ready, out_valid}, 3'b101);

        done_before = n_done;
        base    = n_xfer;
        stalled = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (n_xfer - base < nae && cyc < 500) begin
            if (stall_at >= 0 && !stalled && n_xfer - base == stall_at) begin
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                stalled   = 1'b1;
                out_ready = 1'b1;
            end
            start = poke && (cyc == 1);
            if (start) begin
                num_pass = 4'd1;
                num_addr = 5'd1;
            end
            @(posedge clk); #1; cyc++;
            start = 1'b0;
        end
        out_ready = 1'b0;
        chk("beats", n_xfer - base, nae);
        chk("done_pulse", done, 1'b1);
        chk("idle_after", {busy, out_valid, out_data}, '0);
        @(posedge clk); #1;
        chk("done_once", done, 1'b0);
        chk("done_count", n_done - done_before, 1);
        chk("sb_empty", sb.size(), 0);
        if (poke) chk("no_restart", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_pass = '0; num_addr = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Three passes over two entries with ReLU: 10 and 0 on every lane.
        v = {5, -3, 7, -3, -2, -3};
        run_job(3, 2, 1'b1, v, 0, 1'b0, -1, 1'b0);
`ifdef ACC_SAT_EN
        chk("ovf_clear", ovf, 1'b0);
`endif

        // Same job with input gaps and a 5-cycle output stall.
        run_job(3, 2, 1'b1, v, 0, 1'b1, 1, 1'b0);

        // Output clamp at both signed extremes.
        v = {32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
        run_job(4, 2, 1'b0, v, 0, 1'b0, -1, 1'b0);
`ifdef ACC_SAT_EN
        chk("ovf_set", ovf, 1'b1);
`endif

        // Reset mid-accumulation, then a fresh single-beat job.
        num_pass = 4'd2; num_addr = 5'd2; relu_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_data  = {8{16'd100}};
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int d0;
            d0 = n_done;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_idle", {busy, in_ready, out_valid, done}, 4'b0000);
            @(posedge clk); #1;
            chk("abort_no_done", n_done - d0, 0);
        end
        v = {9};
        run_job(1, 1, 1'b0, v, 0, 1'b0, -1, 1'b0);

        // num_pass=0 / num_addr=20 clamp to 1 x 16, start poked during drain.
        v.delete();
        for (int i = 0; i < 16; i++) v.push_back(i*150 - 1100);
        run_job(0, 20, 1'b1, v, 0, 1'b0, 3, 1'b1);

        // Independent lanes with per-lane offsets and clamp on some lanes.
        v = {1000, -2000, 30000, 5000, -7000, 10000};
        run_job(2, 3, 1'b0, v, -3000, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
